// File: rtl/tx_burst_sequencer.sv
// Drives the DAC core's LFSR transmitter through a run of bursts: reset, enable,
// wait for the flagged burst to finish, idle gap, repeat until done or aborted.
module tx_burst_sequencer #(
   parameter int CNT_WIDTH   = 16,
   parameter int RST_CYCLES  = 4,
   parameter int ARM_TIMEOUT = 100000
) (
   input  logic                 aclk,
   input  logic                 arst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [7:0]           div_i,
   input  logic [2:0]           rep_i,
   input  logic [2:0]           order_i,
   input  logic [CNT_WIDTH-1:0] nburst_i,
   input  logic [CNT_WIDTH-1:0] gap_i,
   input  logic                 tx_flag_i,
   output logic [31:0]          tx_cfg_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic [CNT_WIDTH-1:0] burst_cnt_o
);

   // One shared phase counter covers the RST hold, the ARM timeout and the GAP length.
   localparam int ARM_W = $clog2(ARM_TIMEOUT);
   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int W0    = (CNT_WIDTH > ARM_W) ? CNT_WIDTH : ARM_W;
   localparam int TW    = (W0 > RST_W) ? W0 : RST_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_ARM,
      ST_ACT,
      ST_GAP,
      ST_FIN
   } state_t;

   state_t                 state_reg, state_next;
   logic [TW-1:0]          cnt_reg, cnt_next;
   logic                   flag_reg;
   logic [7:0]             div_reg;
   logic [2:0]             rep_reg;
   logic [2:0]             order_reg;
   logic [CNT_WIDTH-1:0]   nburst_reg;
   logic [CNT_WIDTH-1:0]   gap_reg;
   logic [CNT_WIDTH-1:0]   burst_cnt_reg, burst_cnt_next;
   logic                   timeout_reg, timeout_next;
   logic                   done_reg, done_next;
   logic                   busy_reg, busy_next;
   logic [31:0]            cfg_reg, cfg_next;

   logic                   start_acc;
   logic                   rise;
   logic                   fall;
   logic                   en_now;
   logic [TW-1:0]          gap_last;
   logic [CNT_WIDTH-1:0]   burst_inc;

   assign start_acc = (state_reg == ST_IDLE) && start_i;
   assign rise      = tx_flag_i & ~flag_reg;
   assign fall      = ~tx_flag_i & flag_reg;
   assign gap_last  = TW'(gap_reg) - TW'(1);
   assign burst_inc = burst_cnt_reg + CNT_WIDTH'(1);

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg + TW'(1);
      burst_cnt_next = burst_cnt_reg;
      timeout_next   = timeout_reg;

      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (start_i) begin
               burst_cnt_next = '0;
               timeout_next   = 1'b0;
               state_next     = ST_RST;
            end
         end
         ST_RST: begin
            if (cnt_reg == TW'(RST_CYCLES - 1))
               state_next = ST_ARM;
         end
         ST_ARM: begin
            if (rise)
               state_next = ST_ACT;
            else if (cnt_reg == TW'(ARM_TIMEOUT - 1)) begin
               timeout_next = 1'b1;
               state_next   = ST_IDLE;
            end
         end
         ST_ACT: begin
            if (fall) begin
               burst_cnt_next = burst_inc;
               if ((nburst_reg != '0) && (burst_inc == nburst_reg))
                  state_next = ST_FIN;
               else if (gap_reg == '0)
                  state_next = ST_RST;
               else
                  state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_reg == gap_last)
               state_next = ST_RST;
         end
         ST_FIN: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including a burst ending in the same cycle.
      if ((state_reg != ST_IDLE) && abort_i) begin
         state_next     = ST_IDLE;
         burst_cnt_next = burst_cnt_reg;
         timeout_next   = timeout_reg;
      end

      if (state_next != state_reg)
         cnt_next = '0;

      en_now    = (state_reg == ST_ARM) || (state_reg == ST_ACT);
      cfg_next  = {16'h0000, ~en_now, en_now, order_reg, rep_reg, div_reg};
      busy_next = (state_next != ST_IDLE);
      done_next = (state_next == ST_FIN);
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         flag_reg      <= 1'b0;
         div_reg       <= '0;
         rep_reg       <= '0;
         order_reg     <= '0;
         nburst_reg    <= '0;
         gap_reg       <= '0;
         burst_cnt_reg <= '0;
         timeout_reg   <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         cfg_reg       <= 32'h0000_8000;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         flag_reg      <= tx_flag_i;
         burst_cnt_reg <= burst_cnt_next;
         timeout_reg   <= timeout_next;
         done_reg      <= done_next;
         busy_reg      <= busy_next;
         cfg_reg       <= cfg_next;
         if (start_acc) begin
            div_reg    <= div_i;
            rep_reg    <= rep_i;
            order_reg  <= order_i;
            nburst_reg <= nburst_i;
            gap_reg    <= gap_i;
         end
      end
   end

   assign tx_cfg_o    = cfg_reg;
   assign busy_o      = busy_reg;
   assign done_o      = done_reg;
   assign timeout_o   = timeout_reg;
   assign burst_cnt_o = burst_cnt_reg;

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Directed plus randomized runs of tx_burst_sequencer against a phase-level model:
// srst/en run lengths, latched fields, burst counts, done/timeout/busy behaviour.
module tb_tx_burst_sequencer;

   localparam int RST_C  = 4;
   localparam int ARM_TO = 20;

   logic        aclk = 1'b0;
   logic        arst;
   logic        start_i;
   logic        abort_i;
   logic [7:0]  div_i;
   logic [2:0]  rep_i;
   logic [2:0]  order_i;
   logic [15:0] nburst_i;
   logic [15:0] gap_i;
   logic        tx_flag_i;
   logic [31:0] tx_cfg_o;
   logic        busy_o;
   logic        done_o;
   logic        timeout_o;
   logic [15:0] burst_cnt_o;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Expected words for the current run and the expected sticky timeout.
   logic [31:0] exp_srst_w;
   logic [31:0] exp_en_w;
   logic        exp_to;

   tx_burst_sequencer #(
      .CNT_WIDTH   (16),
      .RST_CYCLES  (RST_C),
      .ARM_TIMEOUT (ARM_TO)
   ) dut (
      .aclk        (aclk),
      .arst        (arst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .div_i       (div_i),
      .rep_i       (rep_i),
      .order_i     (order_i),
      .nburst_i    (nburst_i),
      .gap_i       (gap_i),
      .tx_flag_i   (tx_flag_i),
      .tx_cfg_o    (tx_cfg_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .timeout_o   (timeout_o),
      .burst_cnt_o (burst_cnt_o)
   );

   always #5 aclk = ~aclk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] cfg, input logic busy,
                          input logic done, input logic [15:0] cnt);
      chk({tag, "_cfg"},  tx_cfg_o, cfg);
      chk({tag, "_busy"}, 32'(busy_o), 32'(busy));
      chk({tag, "_done"}, 32'(done_o), 32'(done));
      chk({tag, "_cnt"},  32'(burst_cnt_o), 32'(cnt));
      chk({tag, "_tmo"},  32'(timeout_o), 32'(exp_to));
   endtask

   // Issue a start, then scramble the config inputs: they must have no further effect.
   task automatic start_run(input int nb, input int gp, input logic [7:0] dv,
                            input logic [2:0] rp, input logic [2:0] od, input logic with_abort);
      div_i    = dv;
      rep_i    = rp;
      order_i  = od;
      nburst_i = 16'(nb);
      gap_i    = 16'(gp);
      start_i  = 1'b1;
      abort_i  = with_abort;
      @(negedge aclk);
      start_i  = 1'b0;
      abort_i  = 1'b0;
      div_i    = 8'($urandom);
      rep_i    = 3'($urandom);
      order_i  = 3'($urandom);
      nburst_i = 16'($urandom);
      gap_i    = 16'($urandom);
      exp_srst_w = {16'h0000, 2'b10, od, rp, dv};
      exp_en_w   = {16'h0000, 2'b01, od, rp, dv};
      exp_to     = 1'b0;
      chk("start_busy", 32'(busy_o), 32'd1);
      chk("start_cnt", 32'(burst_cnt_o), 32'd0);
      chk("start_tmo", 32'(timeout_o), 32'd0);
   endtask

   // Count srst samples until en shows up; returns at the first en sample.
   task automatic wait_en(input string tag, input int exp_len, input logic [15:0] cnt);
      int len;
      logic seen;
      len  = 0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge aclk);
         if (tx_cfg_o[14])
            seen = 1'b1;
         else begin
            len++;
            chk_all({tag, "_srst"}, exp_srst_w, 1'b1, 1'b0, cnt);
         end
      end
      chk({tag, "_en_seen"}, 32'(seen), 32'd1);
      chk({tag, "_srst_len"}, 32'(len), 32'(exp_len));
      if (seen)
         chk_all({tag, "_en"}, exp_en_w, 1'b1, 1'b0, cnt);
   endtask

   // Act as the DAC core: raise the flag d samples after en, hold it len cycles, drop it.
   task automatic play_burst(input string tag, input int d, input int len,
                             input logic [15:0] prev_cnt, input logic last, input logic do_abort);
      for (int k = 0; k < d; k++) begin
         @(negedge aclk);
         chk_all({tag, "_arm"}, exp_en_w, 1'b1, 1'b0, prev_cnt);
      end
      tx_flag_i = 1'b1;
      for (int k = 0; k < len; k++) begin
         start_i = (k == 1);
         @(negedge aclk);
         start_i = 1'b0;
         chk_all({tag, "_act"}, exp_en_w, 1'b1, 1'b0, prev_cnt);
         if (do_abort && k == len / 2) begin
            abort_i = 1'b1;
            @(negedge aclk);
            abort_i   = 1'b0;
            tx_flag_i = 1'b0;
            chk_all({tag, "_abort"}, exp_en_w, 1'b0, 1'b0, prev_cnt);
            @(negedge aclk);
            chk_all({tag, "_abort_idle"}, exp_srst_w, 1'b0, 1'b0, prev_cnt);
            return;
         end
      end
      tx_flag_i = 1'b0;
      @(negedge aclk);
      chk_all({tag, "_fall"}, exp_en_w, 1'b1, last, 16'(prev_cnt + 16'd1));
      if (last) begin
         @(negedge aclk);
         chk_all({tag, "_end"}, exp_srst_w, 1'b0, 1'b0, 16'(prev_cnt + 16'd1));
      end
   endtask

   initial begin
      int nb;
      int gp;
      arst       = 1'b1;
      start_i    = 1'b0;
      abort_i    = 1'b0;
      div_i      = '0;
      rep_i      = '0;
      order_i    = '0;
      nburst_i   = '0;
      gap_i      = '0;
      tx_flag_i  = 1'b0;
      exp_srst_w = 32'h0000_8000;
      exp_en_w   = 32'h0000_4000;
      exp_to     = 1'b0;

      @(negedge aclk);
      chk_all("reset", 32'h0000_8000, 1'b0, 1'b0, 16'd0);
      arst = 1'b0;
      @(negedge aclk);
      chk_all("idle", 32'h0000_8000, 1'b0, 1'b0, 16'd0);

      // Two bursts with a 3-cycle gap.
      start_run(2, 3, 8'h11, 3'd1, 3'd2, 1'b0);
      wait_en("t1_b0", RST_C, 16'd0);
      play_burst("t1_b0", 2, 10, 16'd0, 1'b0, 1'b0);
      wait_en("t1_b1", 3 + RST_C, 16'd1);
      play_burst("t1_b1", 2, 10, 16'd1, 1'b1, 1'b0);

      // Field packing against literal words.
      start_run(1, 0, 8'h2A, 3'd5, 3'd3, 1'b0);
      exp_srst_w = 32'h0000_9D2A;
      exp_en_w   = 32'h0000_5D2A;
      wait_en("t2", RST_C, 16'd0);
      play_burst("t2", 1, 6, 16'd0, 1'b1, 1'b0);

      // ARM timeout: en visible for exactly ARM_TO samples, timeout on the last one.
      start_run(1, 0, 8'h77, 3'd4, 3'd1, 1'b0);
      wait_en("t3", RST_C, 16'd0);
      for (int k = 1; k < ARM_TO - 1; k++) begin
         @(negedge aclk);
         chk_all("t3_arm", exp_en_w, 1'b1, 1'b0, 16'd0);
      end
      @(negedge aclk);
      exp_to = 1'b1;
      chk_all("t3_tmo", exp_en_w, 1'b0, 1'b0, 16'd0);
      @(negedge aclk);
      chk_all("t3_idle", exp_srst_w, 1'b0, 1'b0, 16'd0);
      start_run(1, 2, 8'h03, 3'd0, 3'd7, 1'b0);
      wait_en("t3_re", RST_C, 16'd0);
      play_burst("t3_re", 0, 5, 16'd0, 1'b1, 1'b0);

      // Continuous mode, five bursts, then abort inside the sixth.
      start_run(0, 0, 8'hC4, 3'd6, 3'd5, 1'b0);
      for (int b = 0; b < 5; b++) begin
         wait_en("t4", RST_C, 16'(b));
         play_burst("t4", int'($urandom_range(0, 4)), int'($urandom_range(4, 12)),
                    16'(b), 1'b0, 1'b0);
      end
      wait_en("t4_b5", RST_C, 16'd5);
      play_burst("t4_b5", 1, 8, 16'd5, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a gap, then a normal run.
      start_run(3, 6, 8'h5C, 3'd2, 3'd6, 1'b0);
      wait_en("t5", RST_C, 16'd0);
      play_burst("t5", 2, 10, 16'd0, 1'b0, 1'b0);
      @(negedge aclk);
      chk_all("t5_gap", exp_srst_w, 1'b1, 1'b0, 16'd1);
      #2 arst = 1'b1;
      #1 chk_all("t5_arst", 32'h0000_8000, 1'b0, 1'b0, 16'd0);
      @(negedge aclk);
      chk_all("t5_hold", 32'h0000_8000, 1'b0, 1'b0, 16'd0);
      arst = 1'b0;
      start_run(2, 3, 8'h11, 3'd1, 3'd2, 1'b0);
      wait_en("t5_b0", RST_C, 16'd0);
      play_burst("t5_b0", 2, 10, 16'd0, 1'b0, 1'b0);
      wait_en("t5_b1", 3 + RST_C, 16'd1);
      play_burst("t5_b1", 2, 10, 16'd1, 1'b1, 1'b0);

      // Abort alone in IDLE is ignored; start together with abort wins.
      abort_i = 1'b1;
      @(negedge aclk);
      abort_i = 1'b0;
      chk("t6_abort_idle", 32'(busy_o), 32'd0);
      start_run(1, 1, 8'h9E, 3'd3, 3'd4, 1'b1);
      wait_en("t6", RST_C, 16'd0);
      play_burst("t6", 3, 7, 16'd0, 1'b1, 1'b0);

      // Randomized runs.
      for (int r = 0; r < 4; r++) begin
         nb = int'($urandom_range(1, 4));
         gp = int'($urandom_range(0, 5));
         start_run(nb, gp, 8'($urandom), 3'($urandom), 3'($urandom), 1'b0);
         for (int b = 0; b < nb; b++) begin
            wait_en("rnd", (b == 0) ? RST_C : gp + RST_C, 16'(b));
            play_burst("rnd", int'($urandom_range(0, 4)), int'($urandom_range(4, 12)),
                       16'(b), (b == nb - 1), 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
